// File: rtl/cube_scan_scheduler_if.sv
// Frame source / display bus for the LED cube scan scheduler.
//   frame_valid  source offers a frame
//   frame_data   packed frame, layer k at [k*DATA_W +: DATA_W]
//   frame_ready  scheduler can take a frame into its shadow buffer
//   layer_sel    one-hot layer drive, zero while blanked
//   col_data     column drive for the active layer, zero while blanked
//   frame_done   one-cycle pulse at the end of the last layer's slot
// master = pattern source side, slave = scheduler side.
interface cube_scan_scheduler_if #(
  parameter int unsigned NUM_LAYERS = 6,
  parameter int unsigned DATA_W     = 36
);
  logic                         frame_valid;
  logic [NUM_LAYERS*DATA_W-1:0] frame_data;
  logic                         frame_ready;
  logic [NUM_LAYERS-1:0]        layer_sel;
  logic [DATA_W-1:0]            col_data;
  logic                         frame_done;

  modport master (
    output frame_valid, frame_data,
    input  frame_ready, layer_sel, col_data, frame_done
  );

  modport slave (
    input  frame_valid, frame_data,
    output frame_ready, layer_sel, col_data, frame_done
  );
endinterface

// File: rtl/cube_scan_scheduler.sv
// Time-multiplexed layer scan controller for the LED cube.
// Each layer gets a slot of SLOT_CYC clocks: BLANK_CYC blanked clocks
// to suppress ghosting, then the layer's columns are driven. Frames are
// double-buffered; a new frame is swapped in only at a frame boundary.
// Ports:
//   clk_50MHz  system clock
//   reset      asynchronous, active-high
//   enable     scan run/stop
//   bus_if     frame handshake in, layer/column drive and frame_done out
module cube_scan_scheduler #(
  parameter int unsigned SLOT_CYC   = 90195,
  parameter int unsigned BLANK_CYC  = 500,
  parameter int unsigned NUM_LAYERS = 6,
  parameter int unsigned DATA_W     = 36
) (
  input  logic                   clk_50MHz,
  input  logic                   reset,
  input  logic                   enable,
  cube_scan_scheduler_if.slave   bus_if
);

  localparam int unsigned CTR_W   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int unsigned LIDX_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned FRAME_W = NUM_LAYERS * DATA_W;

  localparam logic [CTR_W-1:0]  BLANK_LAST = CTR_W'(BLANK_CYC - 1);
  localparam logic [CTR_W-1:0]  SLOT_LAST  = CTR_W'(SLOT_CYC - 1);
  localparam logic [LIDX_W-1:0] LAYER_LAST = LIDX_W'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CTR_W-1:0]     slot_ctr_q, slot_ctr_d;
  logic [LIDX_W-1:0]    layer_idx_q, layer_idx_d;
  logic [FRAME_W-1:0]   active_q, active_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic                 ready_q, ready_d;
  logic [NUM_LAYERS-1:0] layer_sel_q, layer_sel_d;
  logic [DATA_W-1:0]    col_data_q, col_data_d;
  logic                 frame_done_q, frame_done_d;
  logic                 accept;
  logic                 swap;

  // State and datapath registers
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      slot_ctr_q   <= '0;
      layer_idx_q  <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
      layer_sel_q  <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_ctr_q   <= slot_ctr_d;
      layer_idx_q  <= layer_idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      layer_sel_q  <= layer_sel_d;
      col_data_q   <= col_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state, buffer management and registered output values
  always_comb begin
    state_d      = state_q;
    slot_ctr_d   = slot_ctr_q;
    layer_idx_d  = layer_idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    layer_sel_d  = '0;
    col_data_d   = '0;
    swap         = 1'b0;
    accept       = bus_if.frame_valid & ready_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = BLANK;
          slot_ctr_d  = '0;
          layer_idx_d = '0;
          swap        = pending_q;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_d     = IDLE;
          slot_ctr_d  = '0;
          layer_idx_d = '0;
        end else begin
          slot_ctr_d = slot_ctr_q + CTR_W'(1);
          if (slot_ctr_q == BLANK_LAST) begin
            state_d = ON;
          end
        end
      end
      ON: begin
        if (!enable) begin
          state_d     = IDLE;
          slot_ctr_d  = '0;
          layer_idx_d = '0;
        end else if (slot_ctr_q == SLOT_LAST) begin
          state_d    = BLANK;
          slot_ctr_d = '0;
          if (layer_idx_q == LAYER_LAST) begin
            layer_idx_d  = '0;
            frame_done_d = 1'b1;
            swap         = pending_q;
          end else begin
            layer_idx_d = layer_idx_q + LIDX_W'(1);
          end
        end else begin
          slot_ctr_d = slot_ctr_q + CTR_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        slot_ctr_d  = '0;
        layer_idx_d = '0;
      end
    endcase

    // Swap reads the old shadow, so a frame accepted on the same edge stays pending
    if (swap) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = bus_if.frame_data;
      pending_d = 1'b1;
    end

    ready_d = ~pending_d;

    // Drive values are computed for the upcoming state so they are valid on the first ON cycle
    if (state_d == ON) begin
      layer_sel_d = NUM_LAYERS'(1) << layer_idx_d;
      for (int k = 0; k < int'(NUM_LAYERS); k++) begin
        if (layer_idx_d == LIDX_W'(k)) begin
          col_data_d = active_d[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus_if.frame_ready = ready_q;
  assign bus_if.layer_sel   = layer_sel_q;
  assign bus_if.col_data    = col_data_q;
  assign bus_if.frame_done  = frame_done_q;

endmodule
